// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg: FSM state encoding and default build constants shared by
// the MAC operand feeder.
package mac_feeder_pkg;

  localparam int DEF_A_WIDTH   = 16;
  localparam int DEF_B_WIDTH   = 16;
  localparam int DEF_ACC_WIDTH = 32;
  localparam int DEF_K_MAX     = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_feeder.sv
// mac_feeder: sequences one dot-product job of cfg_k operand beats into an
// external MAC that registers operands one beat ahead of accumulating.
// A trailing zero-operand flush beat drains the last product, after which
// the result is offered via result_valid/result_ready.
// Optional build macro MAC_FEEDER_ABORT_EN adds an abort input that cancels
// a job in flight without producing a result.
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int A_WIDTH           = DEF_A_WIDTH,
  parameter int B_WIDTH           = DEF_B_WIDTH,
  parameter int ACCUMULATOR_WIDTH = DEF_ACC_WIDTH,
  parameter int K_MAX             = DEF_K_MAX,
  localparam int CNT_WIDTH        = $clog2(K_MAX + 1)
) (
  input  logic                                clk,
  input  logic                                arst_in,
  input  logic                                start,
  input  logic        [CNT_WIDTH-1:0]         cfg_k,
  input  logic signed [ACCUMULATOR_WIDTH-1:0] psum_in,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [A_WIDTH-1:0]           in_a,
  input  logic signed [B_WIDTH-1:0]           in_b,
  output logic                                mac_input_valid,
  output logic                                mac_accumulate_internal,
  output logic signed [A_WIDTH-1:0]           mac_a,
  output logic signed [B_WIDTH-1:0]           mac_b,
  output logic signed [ACCUMULATOR_WIDTH-1:0] mac_partial_sum,
  output logic                                result_valid,
  input  logic                                result_ready,
`ifdef MAC_FEEDER_ABORT_EN
  input  logic                                abort,
`endif
  output logic                                busy
);

  localparam logic [CNT_WIDTH-1:0] KMAX_C = CNT_WIDTH'(K_MAX);
  localparam logic [CNT_WIDTH-1:0] ONE_C  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TWO_C  = CNT_WIDTH'(2);

  state_t                                r_state;
  logic        [CNT_WIDTH-1:0]           r_cnt;
  logic        [CNT_WIDTH-1:0]           r_k;
  logic signed [ACCUMULATOR_WIDTH-1:0]   r_psum;

  state_t                                w_state_nxt;
  logic                                  w_start_ok;
  logic                                  w_beat;
  logic                                  w_in_ready;
  logic                                  w_mvalid;
  logic                                  w_acc;
  logic signed [A_WIDTH-1:0]             w_a;
  logic signed [B_WIDTH-1:0]             w_b;
  logic                                  w_rvalid;

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Job configuration latch and beat counter.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_cnt  <= '0;
      r_k    <= '0;
      r_psum <= '0;
    end else if (w_start_ok) begin
      r_cnt  <= '0;
      r_k    <= cfg_k;
      r_psum <= psum_in;
    end else if (w_beat) begin
      r_cnt  <= r_cnt + ONE_C;
    end
  end

  // Next state and MAC drive. Beats 0 and 1 both seed from the partial sum
  // because the MAC adds the product of the previous beat; the flush beat
  // carries zero operands just to push the final product through.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_beat      = 1'b0;
    w_in_ready  = 1'b0;
    w_mvalid    = 1'b0;
    w_acc       = 1'b0;
    w_a         = '0;
    w_b         = '0;
    w_rvalid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && (cfg_k != '0) && (cfg_k <= KMAX_C)) begin
          w_start_ok  = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_beat   = 1'b1;
          w_mvalid = 1'b1;
          w_a      = in_a;
          w_b      = in_b;
          w_acc    = (r_cnt >= TWO_C);
          if (r_cnt == (r_k - ONE_C)) w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        w_mvalid    = 1'b1;
        w_acc       = (r_k >= TWO_C);
        w_state_nxt = HOLD;
      end
      HOLD: begin
        w_rvalid = 1'b1;
        if (result_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
`ifdef MAC_FEEDER_ABORT_EN
    if (abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_beat      = 1'b0;
      w_in_ready  = 1'b0;
      w_mvalid    = 1'b0;
      w_acc       = 1'b0;
      w_a         = '0;
      w_b         = '0;
      w_rvalid    = 1'b0;
    end
`endif
  end

  assign in_ready                = w_in_ready;
  assign mac_input_valid         = w_mvalid;
  assign mac_accumulate_internal = w_acc;
  assign mac_a                   = w_a;
  assign mac_b                   = w_b;
  assign mac_partial_sum         = r_psum;
  assign result_valid            = w_rvalid;
  assign busy                    = (r_state != IDLE);

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: directed bench for mac_feeder with a behavioural MAC,
// an expected-beat scoreboard and an expected-result scoreboard.
module tb_mac_feeder;

  localparam int CNT_W = $clog2(256 + 1);

  typedef struct {
    logic               acc;
    logic signed [15:0] a;
    logic signed [15:0] b;
  } beat_t;

  logic               clk = 1'b0;
  logic               arst_in;
  logic               start;
  logic [CNT_W-1:0]   cfg_k;
  logic signed [31:0] psum_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_a;
  logic signed [15:0] in_b;
  logic               mac_input_valid;
  logic               mac_accumulate_internal;
  logic signed [15:0] mac_a;
  logic signed [15:0] mac_b;
  logic signed [31:0] mac_partial_sum;
  logic               result_valid;
  logic               result_ready;
  logic               busy;
`ifdef MAC_FEEDER_ABORT_EN
  logic               abort;
`endif

  int n_checks = 0;
  int n_err    = 0;

  beat_t q_beat[$];
  int    q_res[$];
  beat_t e_beat;
  int    e_res;
  logic signed [31:0] exp_psum = 0;
  logic signed [15:0] ja[256];
  logic signed [15:0] jb[256];

  // Behavioural MAC: operands registered one beat ahead of accumulation.
  logic signed [31:0] m_prod = 0;
  logic signed [31:0] m_out  = 0;

  mac_feeder dut (
    .clk                     (clk),
    .arst_in                 (arst_in),
    .start                   (start),
    .cfg_k                   (cfg_k),
    .psum_in                 (psum_in),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .in_a                    (in_a),
    .in_b                    (in_b),
    .mac_input_valid         (mac_input_valid),
    .mac_accumulate_internal (mac_accumulate_internal),
    .mac_a                   (mac_a),
    .mac_b                   (mac_b),
    .mac_partial_sum         (mac_partial_sum),
    .result_valid            (result_valid),
    .result_ready            (result_ready),
`ifdef MAC_FEEDER_ABORT_EN
    .abort                   (abort),
`endif
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (mac_input_valid) begin
      m_out  <= (mac_accumulate_internal ? m_out : mac_partial_sum) + m_prod;
      m_prod <= 32'(mac_a) * 32'(mac_b);
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!arst_in) begin
      check("psum_out", longint'(mac_partial_sum), longint'(exp_psum));
      if (mac_input_valid) begin
        if (q_beat.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e_beat = q_beat.pop_front();
          check("beat_acc", longint'(mac_accumulate_internal), longint'(e_beat.acc));
          check("beat_a", longint'(mac_a), longint'(e_beat.a));
          check("beat_b", longint'(mac_b), longint'(e_beat.b));
        end
      end else begin
        check("idle_a_zero", longint'(mac_a), 0);
        check("idle_b_zero", longint'(mac_b), 0);
      end
      if (result_valid && result_ready) begin
        if (q_res.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e_res = q_res.pop_front();
          check("mac_result", longint'(m_out), longint'(e_res));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int k, input int psum);
    start   = 1'b1;
    cfg_k   = CNT_W'(k);
    psum_in = psum;
    tick();
    start    = 1'b0;
    exp_psum = psum;
  endtask

  // One full job using ja/jb, with 'gap' idle cycles before each later beat
  // and 'hold' cycles of result_ready low in HOLD (start pulsed meanwhile).
  task automatic run_job(input int k, input int psum, input int gap, input int hold);
    int    sum;
    beat_t b;
    sum = psum;
    start_job(k, psum);
    check("busy_run", longint'(busy), 1);
    for (int j = 0; j < k; j++) begin
      for (int g = 0; g < ((j == 0) ? 0 : gap); g++) begin
        in_valid = 1'b0;
        @(negedge clk);
        check("gap_no_beat", longint'(mac_input_valid), 0);
        tick();
      end
      in_valid = 1'b1;
      in_a     = ja[j];
      in_b     = jb[j];
      b.acc = (j >= 2);
      b.a   = ja[j];
      b.b   = jb[j];
      q_beat.push_back(b);
      sum += int'(ja[j]) * int'(jb[j]);
      @(negedge clk);
      check("run_ready", longint'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    b.acc = (k >= 2);
    b.a   = '0;
    b.b   = '0;
    q_beat.push_back(b);
    q_res.push_back(sum);
    @(negedge clk);
    check("flush_no_rv", longint'(result_valid), 0);
    check("flush_not_ready", longint'(in_ready), 0);
    tick();
    result_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rv", longint'(result_valid), 1);
      check("hold_no_beat", longint'(mac_input_valid), 0);
      check("hold_busy", longint'(busy), 1);
      check("hold_not_ready", longint'(in_ready), 0);
      start = 1'b1;
      cfg_k = CNT_W'(2);
      tick();
    end
    start        = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    check("rv_after_2", longint'(result_valid), 1);
    tick();
    @(negedge clk);
    check("done_busy", longint'(busy), 0);
    check("done_rv", longint'(result_valid), 0);
  endtask

  task automatic bad_start(input int k);
    start = 1'b1;
    cfg_k = CNT_W'(k);
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_a     = 16'sd5;
    in_b     = 16'sd5;
    @(negedge clk);
    check("bad_k_busy", longint'(busy), 0);
    check("bad_k_ready", longint'(in_ready), 0);
    check("bad_k_beat", longint'(mac_input_valid), 0);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    arst_in = 1'b1; start = 1'b0; cfg_k = '0; psum_in = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; result_ready = 1'b1;
`ifdef MAC_FEEDER_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    check("rst_busy", longint'(busy), 0);
    check("rst_ready", longint'(in_ready), 0);
    check("rst_miv", longint'(mac_input_valid), 0);
    check("rst_rv", longint'(result_valid), 0);
    check("rst_psum", longint'(mac_partial_sum), 0);
    arst_in = 1'b0;
    tick();

    // K=3 back to back: 10 + 4 + 10 + 18 = 42
    ja[0] = 1; ja[1] = 2; ja[2] = 3;
    jb[0] = 4; jb[1] = 5; jb[2] = 6;
    run_job(3, 10, 0, 0);

    // K=1 negative product
    ja[0] = -3; jb[0] = 7;
    run_job(1, 0, 0, 0);

    // K=3 with 2-cycle gaps
    ja[0] = 1; ja[1] = 2; ja[2] = 3;
    jb[0] = 4; jb[1] = 5; jb[2] = 6;
    run_job(3, 10, 2, 0);

    // Ignored starts: zero and above K_MAX
    bad_start(0);
    bad_start(257);

    // K=2 with extreme operands, 5-cycle back-pressure in HOLD
    ja[0] = -32768; jb[0] = -32768; ja[1] = 32767; jb[1] = -32768;
    run_job(2, -7, 0, 5);

    // K = K_MAX with random operands
    for (int i = 0; i < 256; i++) begin
      ja[i] = 16'($urandom_range(0, 65535));
      jb[i] = 16'($urandom_range(0, 65535));
    end
    run_job(256, 123, 0, 0);

    // Reset after the first beat of a K=4 job
    start_job(4, 5);
    begin
      beat_t b;
      b.acc = 1'b0; b.a = 16'sd7; b.b = 16'sd3;
      q_beat.push_back(b);
    end
    in_valid = 1'b1; in_a = 16'sd7; in_b = 16'sd3;
    tick();
    arst_in = 1'b1;
    #1;
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_miv", longint'(mac_input_valid), 0);
    check("mid_rst_ready", longint'(in_ready), 0);
    check("mid_rst_psum", longint'(mac_partial_sum), 0);
    check("mid_rst_acc", longint'(mac_accumulate_internal), 0);
    exp_psum = 0;
    #1;
    arst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_busy", longint'(busy), 0);
      check("post_rst_rv", longint'(result_valid), 0);
      tick();
    end
    in_valid = 1'b0;

`ifdef MAC_FEEDER_ABORT_EN
    // Abort after the first beat of a K=4 job
    start_job(4, 9);
    begin
      beat_t b;
      b.acc = 1'b0; b.a = 16'sd2; b.b = 16'sd2;
      q_beat.push_back(b);
    end
    in_valid = 1'b1; in_a = 16'sd2; in_b = 16'sd2;
    tick();
    abort = 1'b1;
    @(negedge clk);
    check("abort_miv", longint'(mac_input_valid), 0);
    check("abort_ready", longint'(in_ready), 0);
    tick();
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_abort_busy", longint'(busy), 0);
      check("post_abort_rv", longint'(result_valid), 0);
      tick();
    end
    in_valid = 1'b0;
`endif

    tick();
    check("beats_left", longint'(q_beat.size()), 0);
    check("results_left", longint'(q_res.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 SHALL have parameter A_WIDTH, default 16, operand a width.
REQ-002 SHALL have parameter B_WIDTH, default 16, operand b width.
REQ-003 SHALL have parameter ACCUMULATOR_WIDTH, default 32, partial-sum width.
REQ-004 SHALL have parameter K_MAX, default 256, maximum dot-product length; CNT_WIDTH = $clog2(K_MAX+1).
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port arst_in  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports start in 1 (job request pulse), cfg_k in CNT_WIDTH (dot-product length), psum_in in ACCUMULATOR_WIDTH (accumulation seed).
REQ-008 SHALL have ports in_valid in 1, in_ready out 1, in_a in A_WIDTH signed, in_b in B_WIDTH signed (upstream operand stream).
REQ-009 SHALL have ports mac_input_valid out 1, mac_accumulate_internal out 1, mac_a out A_WIDTH, mac_b out B_WIDTH, mac_partial_sum out ACCUMULATOR_WIDTH (drive the MAC).
REQ-010 SHALL have ports result_valid out 1, result_ready in 1, busy out 1.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FLUSH, HOLD.
REQ-012 IDLE: start=1 with cfg_k in 1..K_MAX SHALL latch cfg_k and psum_in, clear beat counter, go to RUN; start with cfg_k=0 or >K_MAX SHALL be ignored.
REQ-013 RUN: in_ready=1; each in_valid&in_ready cycle SHALL be one beat: mac_input_valid=1, mac_a=in_a, mac_b=in_b, counter+1.
REQ-014 RUN: cycles without in_valid SHALL drive mac_input_valid=0 (MAC holds).
REQ-015 Beat j SHALL drive mac_accumulate_internal = (j>=2); beat 1 restarts from mac_partial_sum because the MAC registers operands one beat before accumulating.
REQ-016 Acceptance of beat K-1 SHALL move to FLUSH.
REQ-017 FLUSH: exactly one cycle, mac_input_valid=1, mac_a=mac_b=0, mac_accumulate_internal=(K>=2), then HOLD.
REQ-018 HOLD: result_valid=1, in_ready=0, mac_input_valid=0; result_valid&result_ready SHALL return to IDLE; start ignored.
REQ-019 mac_partial_sum SHALL equal latched psum for the whole job; mac_a/mac_b SHALL be 0 whenever mac_input_valid=0.
REQ-020 busy SHALL be 1 in every state except IDLE; in_ready SHALL be 0 outside RUN.
REQ-021 Latency: result_valid SHALL assert exactly 2 cycles after acceptance of beat K-1.

Reset
REQ-022 arst_in=1 SHALL force IDLE immediately, counter 0, latched k/psum 0, all outputs 0, including mid-job; no result produced for the interrupted job.

Configuration
REQ-023 Macro MAC_FEEDER_ABORT_EN defined: SHALL add port abort in 1; abort=1 in any non-IDLE state SHALL drive mac_input_valid=0 that cycle and enter IDLE next cycle without result_valid; abort in IDLE ignored.
REQ-024 Macro undefined: abort port SHALL not exist; jobs end only via HOLD handshake or reset.

Structure
REQ-025 Shared package mac_feeder_pkg SHALL hold the state enum typedef and default width/K_MAX constants.
REQ-026 No sub-module; counter and FSM SHALL be inline.

Verification
REQ-027 K=3, psum=10, a=(1,2,3), b=(4,5,6) back-to-back -> accumulate sequence 0,0,1,1; result_valid 2 cycles after 3rd beat; MAC out=42.
REQ-028 K=1, psum=0, a=-3, b=7 -> flush accumulate=0; MAC out=-21.
REQ-029 K=3 data of REQ-027 with 2-cycle in_valid gaps between beats -> no mac_input_valid in gaps; out=42.
REQ-030 start with cfg_k=0 -> busy stays 0, in_ready 0, no MAC beats.
REQ-031 result_ready low 5 cycles in HOLD, start pulsed -> result_valid held, mac_input_valid 0, state unchanged until handshake.
REQ-032 arst_in pulse after beat 1 of K=4 (and abort with MAC_FEEDER_ABORT_EN) -> IDLE next cycle, all outputs 0, no result_valid.
